// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter for two byte sources feeding a TX FIFO that drains into an
// 8N1 UART serializer. Tx_Serial, tx_busy and fifo_count are registered.
module uart_tx_arbiter #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int FIFO_DEPTH   = 8,
  parameter int PTR_W        = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_cpu,
  input  logic [7:0]       data_cpu,
  output logic             gnt_cpu,
  input  logic             req_echo,
  input  logic [7:0]       data_echo,
  output logic             gnt_echo,
  output logic             Tx_Serial,
  output logic             tx_busy,
  output logic [PTR_W:0]   fifo_count
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             prefer_echo;
  state_t           state, state_n;
  logic [CNT_W-1:0] baud_cnt, baud_n;
  logic [2:0]       bit_idx, bit_n;
  logic [7:0]       shift, shift_n;
  logic             tx_n, busy_n;
  logic             full, empty, push, pop, bit_done;
  logic [7:0]       push_data;

  // full comes from the registered count, so a same-cycle pop never frees a slot
  assign full      = (fifo_count == FULL_COUNT);
  assign empty     = (fifo_count == '0);
  assign gnt_cpu   = !reset && !full && req_cpu  && (!req_echo || !prefer_echo);
  assign gnt_echo  = !reset && !full && req_echo && (!req_cpu  ||  prefer_echo);
  assign push      = gnt_cpu | gnt_echo;
  assign push_data = gnt_cpu ? data_cpu : data_echo;
  assign bit_done  = (baud_cnt == BAUD_LAST);

  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_idx;
    shift_n = shift;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        baud_n = '0;
        bit_n  = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          state_n = START;
        end
      end
      START: begin
        if (bit_done) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = DATA;
        end else begin
          baud_n = baud_cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_done) begin
          baud_n = '0;
          if (bit_idx == 3'd7) state_n = STOP;
          else                 bit_n   = bit_idx + 3'd1;
        end else begin
          baud_n = baud_cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_done) begin
          baud_n = '0;
          bit_n  = '0;
          // back-to-back frames: reload straight into START when data is waiting
          if (!empty) begin
            pop     = 1'b1;
            shift_n = mem[rd_ptr];
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          baud_n = baud_cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    // line level is decoded from the next state so the pin itself is a flop
    tx_n   = (state_n == START) ? 1'b0 :
             (state_n == DATA)  ? shift_n[bit_n] : 1'b1;
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      baud_cnt    <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      Tx_Serial   <= 1'b1;
      tx_busy     <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      prefer_echo <= 1'b0;
    end else begin
      state     <= state_n;
      baud_cnt  <= baud_n;
      bit_idx   <= bit_n;
      shift     <= shift_n;
      Tx_Serial <= tx_n;
      tx_busy   <= busy_n;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (PTR_W+1)'(1);
        2'b01:   fifo_count <= fifo_count - (PTR_W+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (gnt_cpu)       prefer_echo <= 1'b1;
      else if (gnt_echo) prefer_echo <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed plus randomized bench for uart_tx_arbiter; a frame-timer model predicts
// grants, occupancy and the serial line level every cycle.
module tb_uart_tx_arbiter;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;
  localparam int FRAME = 10 * CPB;

  logic       clk, reset;
  logic       req_cpu, req_echo;
  logic [7:0] data_cpu, data_echo;
  logic       gnt_cpu, gnt_echo, Tx_Serial, tx_busy;
  logic [3:0] fifo_count;

  uart_tx_arbiter #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .PTR_W(3)) dut (
    .clk(clk), .reset(reset),
    .req_cpu(req_cpu), .data_cpu(data_cpu), .gnt_cpu(gnt_cpu),
    .req_echo(req_echo), .data_echo(data_echo), .gnt_echo(gnt_echo),
    .Tx_Serial(Tx_Serial), .tx_busy(tx_busy), .fifo_count(fifo_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int         checks = 0;
  int         errors = 0;
  logic [7:0] model_q [$];
  int         timer;
  logic [7:0] cur_byte;
  logic       pref_echo_m;
  logic       last_gc, last_ge;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame position p counts cycles since the start bit: bit slot p/CPB is
  // 0 = start, 1..8 = data LSB first, 9 = stop.
  function automatic logic exp_tx();
    int p, b;
    if (timer == 0) return 1'b1;
    p = FRAME - timer;
    b = p / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return cur_byte[b-1];
    return 1'b1;
  endfunction

  task automatic model_reset();
    model_q.delete();
    timer       = 0;
    pref_echo_m = 1'b0;
  endtask

  task automatic applyStimulus(input logic rc, input logic [7:0] dc,
                               input logic re, input logic [7:0] de);
    logic full_m, eg_c, eg_e;
    req_cpu = rc; data_cpu = dc; req_echo = re; data_echo = de;
    #1;
    full_m = (model_q.size() == DEPTH);
    eg_c   = !full_m && rc && (!re || !pref_echo_m);
    eg_e   = !full_m && re && (!rc ||  pref_echo_m);
    checkOutput("gnt_cpu", gnt_cpu, eg_c);
    checkOutput("gnt_echo", gnt_echo, eg_e);
    last_gc = eg_c;
    last_ge = eg_e;
    if (timer <= 1 && model_q.size() > 0) begin
      cur_byte = model_q.pop_front();
      timer    = FRAME;
    end else if (timer > 0) begin
      timer--;
    end
    if (eg_c) begin
      model_q.push_back(dc);
      pref_echo_m = 1'b1;
    end else if (eg_e) begin
      model_q.push_back(de);
      pref_echo_m = 1'b0;
    end
    @(posedge clk);
    #1;
    checkOutput("tx_serial", Tx_Serial, exp_tx());
    checkOutput("tx_busy", tx_busy, timer > 0);
    checkOutput("fifo_count", fifo_count, model_q.size());
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((timer != 0 || model_q.size() != 0) && guard < 2000) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
      guard++;
    end
    checkOutput("drain_bound", guard < 2000, 1'b1);
    idle_cycles(3);
  endtask

  initial begin
    int ci, ei, sent, guard;
    logic saw_full;
    logic pc, pe;
    logic [7:0] dc, de;

    reset = 1'b1;
    req_cpu = 1'b0; req_echo = 1'b0; data_cpu = 8'h00; data_echo = 8'h00;
    model_reset();
    #1 req_cpu = 1'b1;
    #1;
    checkOutput("reset_gnt_cpu", gnt_cpu, 1'b0);
    checkOutput("reset_tx", Tx_Serial, 1'b1);
    checkOutput("reset_busy", tx_busy, 1'b0);
    checkOutput("reset_count", fifo_count, 0);
    req_cpu = 1'b0;
    #8 reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post_reset_tx", Tx_Serial, 1'b1);
    checkOutput("post_reset_count", fifo_count, 0);

    $display("[TB] single frame 0x55");
    applyStimulus(1'b1, 8'h55, 1'b0, 8'h00);
    idle_cycles(FRAME + 5);

    $display("[TB] alternating grants");
    ci = 0; ei = 0;
    for (int k = 0; k < 60 && (ci < 4 || ei < 4); k++) begin
      applyStimulus(ci < 4, 8'hA1 + 8'(ci), ei < 4, 8'hB1 + 8'(ei));
      if (last_gc) ci++;
      if (last_ge) ei++;
    end
    checkOutput("alt_cpu_done", ci, 4);
    checkOutput("alt_echo_done", ei, 4);
    drain();

    $display("[TB] ten cpu pushes into a busy serializer");
    sent = 0; saw_full = 1'b0;
    for (int k = 0; k < 600 && sent < 10; k++) begin
      applyStimulus(1'b1, 8'h10 + 8'(sent), 1'b0, 8'h00);
      if (last_gc) sent++;
      if (fifo_count == 4'd8) saw_full = 1'b1;
    end
    checkOutput("cpu10_sent", sent, 10);
    checkOutput("fifo_saturated", saw_full, 1'b1);
    drain();

    $display("[TB] full fifo then echo request");
    sent = 0;
    for (int k = 0; k < 50 && sent < 9; k++) begin
      applyStimulus(1'b1, 8'h60 + 8'(sent), 1'b0, 8'h00);
      if (last_gc) sent++;
    end
    checkOutput("full_fill_count", fifo_count, 8);
    guard = 0;
    last_ge = 1'b0;
    while (!last_ge && guard < 200) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 8'hE7);
      guard++;
    end
    checkOutput("echo_grant_bound", last_ge, 1'b1);
    drain();

    $display("[TB] push landing before the last stop cycle");
    applyStimulus(1'b1, 8'hC3, 1'b0, 8'h00);
    guard = 0;
    while (timer != 2 && guard < 100) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
      guard++;
    end
    checkOutput("stop_wait_bound", timer, 2);
    applyStimulus(1'b1, 8'h3C, 1'b0, 8'h00);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
    checkOutput("no_gap_start", Tx_Serial, 1'b0);
    drain();

    $display("[TB] reset during data bit 3");
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 8'h80 + 8'(k), 1'b0, 8'h00);
    guard = 0;
    while (!(timer > 0 && (FRAME - timer) / CPB == 4) && guard < 100) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
      guard++;
    end
    checkOutput("bit3_queued", fifo_count, 3);
    #2 reset = 1'b1;
    #1;
    checkOutput("abort_tx", Tx_Serial, 1'b1);
    checkOutput("abort_count", fifo_count, 0);
    checkOutput("abort_busy", tx_busy, 1'b0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 8'h0F, 1'b0, 8'h00);
    drain();

    $display("[TB] randomized traffic");
    pc = 1'b0; pe = 1'b0; dc = 8'h00; de = 8'h00;
    for (int k = 0; k < 800; k++) begin
      if (!pc && $urandom_range(0, 5) == 0) begin pc = 1'b1; dc = 8'($urandom); end
      if (!pe && $urandom_range(0, 5) == 0) begin pe = 1'b1; de = 8'($urandom); end
      applyStimulus(pc, dc, pe, de);
      if (last_gc) pc = 1'b0;
      if (last_ge) pe = 1'b0;
    end
    guard = 0;
    while ((pc || pe) && guard < 2000) begin
      applyStimulus(pc, dc, pe, de);
      if (last_gc) pc = 1'b0;
      if (last_ge) pe = 1'b0;
      guard++;
    end
    checkOutput("random_reqs_served", pc | pe, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
